// File: rtl/f2h_burst_writer_if.sv
// AXI3 write-only channel bundle between f2h_burst_writer (master) and the
// HPS F2H slave port.
interface f2h_burst_writer_if;
    logic [7:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic [4:0]  awuser;
    logic        awvalid;
    logic        awready;
    logic [7:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [7:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awuser, awvalid,
        output wid, wdata, wstrb, wlast, wvalid, bready,
        input  awready, wready, bid, bresp, bvalid
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awuser, awvalid,
        input  wid, wdata, wstrb, wlast, wvalid, bready,
        output awready, wready, bid, bresp, bvalid
    );
endinterface

// File: rtl/f2h_burst_writer.sv
// Sample FIFO plus AXI3 INCR burst sequencer writing a circular DDR buffer.
// Optional macro F2H_BURST_WRITER_FLUSH_EN: short flush burst when enable falls.
module f2h_burst_writer #(
    parameter int          BURST_LEN  = 16,
    parameter int          FIFO_DEPTH = 32,
    parameter logic [7:0]  AXI_ID     = 8'h00,
    parameter logic [3:0]  AXI_CACHE  = 4'b0011,
    parameter logic [4:0]  AXI_USER   = 5'b00000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [31:0]         base_addr,
    input  logic [23:0]         buf_words,
    input  logic [31:0]         s_data,
    input  logic                s_valid,
    output logic                s_ready,
    f2h_burst_writer_if.master  axi,
    output logic [23:0]         wr_ptr,
    output logic                busy,
    output logic                overflow,
    output logic                bresp_err
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] BL_C    = CW'(BURST_LEN);
    localparam logic [4:0]    BL5_C   = 5'(BURST_LEN);
    localparam logic [PW-1:0] ONE_P   = PW'(1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_AW = 2'd1, S_W = 2'd2, S_B = 2'd3} state_t;

    state_t        state_q, state_d;
    logic          en_prev_q, en_prev_d;
    logic [23:0]   offset_q, offset_d;
    logic [23:0]   wr_ptr_q, wr_ptr_d;
    logic          overflow_q, overflow_d;
    logic          bresp_err_q, bresp_err_d;
    logic [31:0]   awaddr_q, awaddr_d;
    logic [4:0]    len_q, len_d;
    logic [4:0]    beat_q, beat_d;
    logic [PW-1:0] wr_idx_q, wr_idx_d;
    logic [PW-1:0] rd_idx_q, rd_idx_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   mem_q [FIFO_DEPTH];

    logic          rise_s;
    logic          s_ready_s;
    logic          fifo_wr_s;
    logic          fifo_rd_s;
    logic          w_last_s;
    logic [23:0]   off_sum_s;
    logic [23:0]   off_next_s;
    logic [31:0]   launch_addr_s;
    logic          unused_bid_s;

    assign rise_s        = enable && !en_prev_q;
    // s_ready comes from the registered count and stays low on the flush cycle.
    assign s_ready_s     = enable && en_prev_q && (count_q != DEPTH_C);
    assign fifo_wr_s     = s_valid && s_ready_s;
    assign fifo_rd_s     = (state_q == S_W) && axi.wready;
    assign w_last_s      = (beat_q == (len_q - 5'd1));
    assign launch_addr_s = base_addr + {6'd0, offset_q, 2'b00};
    assign unused_bid_s  = ^axi.bid;

`ifdef F2H_BURST_WRITER_FLUSH_EN
    logic fall_s;
    assign fall_s = !enable && en_prev_q;
`endif

    // Offset after the current burst, wrapping at the end of the buffer.
    always_comb begin
        off_sum_s = offset_q + {19'd0, len_q};
        if (off_sum_s >= buf_words) begin
            off_next_s = off_sum_s - buf_words;
        end else begin
            off_next_s = off_sum_s;
        end
    end

    // Next-state logic for the burst FSM, FIFO pointers and status flags.
    always_comb begin
        state_d     = state_q;
        en_prev_d   = enable;
        offset_d    = offset_q;
        wr_ptr_d    = wr_ptr_q;
        overflow_d  = overflow_q;
        bresp_err_d = bresp_err_q;
        awaddr_d    = awaddr_q;
        len_d       = len_q;
        beat_d      = beat_q;
        wr_idx_d    = wr_idx_q;
        rd_idx_d    = rd_idx_q;
        count_d     = count_q;

        case (state_q)
            S_IDLE: begin
                if (enable && en_prev_q && (count_q >= BL_C)) begin
                    state_d  = S_AW;
                    len_d    = BL5_C;
                    awaddr_d = launch_addr_s;
                end
`ifdef F2H_BURST_WRITER_FLUSH_EN
                else if (fall_s && (count_q != {CW{1'b0}}) && (count_q < BL_C)) begin
                    state_d  = S_AW;
                    len_d    = 5'(count_q);
                    awaddr_d = launch_addr_s;
                end
`endif
                else begin
                    state_d = S_IDLE;
                end
            end
            S_AW: begin
                if (axi.awready) begin
                    state_d  = S_W;
                    offset_d = off_next_s;
                    beat_d   = 5'd0;
                end else begin
                    state_d = S_AW;
                end
            end
            S_W: begin
                if (axi.wready) begin
                    if (w_last_s) begin
                        state_d = S_B;
                        beat_d  = 5'd0;
                    end else begin
                        beat_d = beat_q + 5'd1;
                    end
                end else begin
                    beat_d = beat_q;
                end
            end
            S_B: begin
                // offset_q already holds this burst's end offset since the AW handshake.
                if (axi.bvalid) begin
                    state_d  = S_IDLE;
                    wr_ptr_d = offset_q;
                    if (axi.bresp != 2'b00) begin
                        bresp_err_d = 1'b1;
                    end else begin
                        bresp_err_d = bresp_err_q;
                    end
                end else begin
                    state_d = S_B;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (rise_s) begin
            wr_idx_d    = {PW{1'b0}};
            rd_idx_d    = {PW{1'b0}};
            count_d     = {CW{1'b0}};
            offset_d    = 24'd0;
            wr_ptr_d    = 24'd0;
            overflow_d  = 1'b0;
            bresp_err_d = 1'b0;
        end else begin
            if (fifo_wr_s) begin
                wr_idx_d = wr_idx_q + ONE_P;
            end else begin
                wr_idx_d = wr_idx_q;
            end
            if (fifo_rd_s) begin
                rd_idx_d = rd_idx_q + ONE_P;
            end else begin
                rd_idx_d = rd_idx_q;
            end
            count_d = count_q + CW'(fifo_wr_s) - CW'(fifo_rd_s);
            if (enable && s_valid && !s_ready_s) begin
                overflow_d = 1'b1;
            end else begin
                overflow_d = overflow_q;
            end
        end
    end

    // State and control registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            en_prev_q   <= 1'b0;
            offset_q    <= 24'd0;
            wr_ptr_q    <= 24'd0;
            overflow_q  <= 1'b0;
            bresp_err_q <= 1'b0;
            awaddr_q    <= 32'd0;
            len_q       <= 5'd0;
            beat_q      <= 5'd0;
            wr_idx_q    <= {PW{1'b0}};
            rd_idx_q    <= {PW{1'b0}};
            count_q     <= {CW{1'b0}};
        end else begin
            state_q     <= state_d;
            en_prev_q   <= en_prev_d;
            offset_q    <= offset_d;
            wr_ptr_q    <= wr_ptr_d;
            overflow_q  <= overflow_d;
            bresp_err_q <= bresp_err_d;
            awaddr_q    <= awaddr_d;
            len_q       <= len_d;
            beat_q      <= beat_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            count_q     <= count_d;
        end
    end

    // Sample storage; emptiness is tracked by count_q, so no reset is needed.
    always_ff @(posedge clk) begin
        if (fifo_wr_s) begin
            mem_q[wr_idx_q] <= s_data;
        end
    end

    assign s_ready     = s_ready_s;
    assign wr_ptr      = wr_ptr_q;
    assign busy        = (state_q != S_IDLE);
    assign overflow    = overflow_q;
    assign bresp_err   = bresp_err_q;

    assign axi.awid    = AXI_ID;
    assign axi.awaddr  = awaddr_q;
    assign axi.awlen   = 4'(len_q - 5'd1);
    assign axi.awsize  = 3'b010;
    assign axi.awburst = 2'b01;
    assign axi.awlock  = 2'b00;
    assign axi.awcache = AXI_CACHE;
    assign axi.awprot  = 3'b000;
    assign axi.awuser  = AXI_USER;
    assign axi.awvalid = (state_q == S_AW);
    assign axi.wid     = AXI_ID;
    assign axi.wdata   = mem_q[rd_idx_q];
    assign axi.wstrb   = 4'hF;
    assign axi.wlast   = (state_q == S_W) && w_last_s;
    assign axi.wvalid  = (state_q == S_W);
    assign axi.bready  = (state_q == S_B);
endmodule

// File: tb/tb_f2h_burst_writer.sv
// Scoreboard bench for f2h_burst_writer: expected AW/W traffic is queued as
// samples are accepted and checked by a monitor as the DUT emits it.
module tb_f2h_burst_writer;
    localparam int BL = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [31:0] base_addr;
    logic [23:0] buf_words;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [23:0] wr_ptr;
    logic        busy;
    logic        overflow;
    logic        bresp_err;

    f2h_burst_writer_if axi();

    f2h_burst_writer #(.BURST_LEN(BL), .FIFO_DEPTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .base_addr(base_addr), .buf_words(buf_words),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .axi(axi),
        .wr_ptr(wr_ptr), .busy(busy), .overflow(overflow), .bresp_err(bresp_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } wexp_t;

    wexp_t       exp_w_q[$];
    logic [31:0] exp_awaddr_q[$];
    logic [3:0]  exp_awlen_q[$];
    wexp_t       mon_e;
    logic [31:0] mon_a;
    logic [3:0]  mon_l;

    int vectors = 0;
    int miscompares = 0;
    int aw_seen = 0;
    int w_seen = 0;
    int model_cnt = 0;
    int model_off = 0;
    bit err_next = 1'b0;
    bit aw_stall = 1'b0;
    bit w_rand = 1'b0;

    // Slave-side responder: awready/wready policy and a one-cycle B response.
    initial begin
        forever begin
            @(posedge clk); #1;
            axi.awready = !aw_stall;
            axi.wready  = w_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (axi.bvalid) begin
                axi.bvalid = 1'b0;
                axi.bresp  = 2'b00;
                err_next   = 1'b0;
            end else if (axi.bready) begin
                axi.bvalid = 1'b1;
                axi.bresp  = err_next ? 2'b10 : 2'b00;
            end
        end
    end

    // Monitor: handshakes seen mid-cycle complete on the next rising edge.
    always @(negedge clk) begin
        if (reset_n && axi.awvalid && axi.awready) begin
            aw_seen++;
            vectors++;
            if (exp_awaddr_q.size() == 0) begin
                miscompares++;
                $display("FAIL aw_unexpected: got awaddr=%h, required no AW", axi.awaddr);
            end else begin
                mon_a = exp_awaddr_q.pop_front();
                mon_l = exp_awlen_q.pop_front();
                if (axi.awaddr !== mon_a || axi.awlen !== mon_l) begin
                    miscompares++;
                    $display("FAIL aw: got addr=%h len=%0d, required addr=%h len=%0d",
                             axi.awaddr, axi.awlen, mon_a, mon_l);
                end
            end
        end
        if (reset_n && axi.wvalid && axi.wready) begin
            w_seen++;
            vectors++;
            if (exp_w_q.size() == 0) begin
                miscompares++;
                $display("FAIL w_unexpected: got wdata=%h, required no beat", axi.wdata);
            end else begin
                mon_e = exp_w_q.pop_front();
                if (axi.wdata !== mon_e.data || axi.wlast !== mon_e.last) begin
                    miscompares++;
                    $display("FAIL w: got data=%h last=%b, required data=%h last=%b",
                             axi.wdata, axi.wlast, mon_e.data, mon_e.last);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    task automatic model_accept(input logic [31:0] d);
        wexp_t e;
        e.data = d;
        e.last = 1'b0;
        model_cnt++;
        if (model_cnt == BL) begin
            e.last = 1'b1;
            exp_awaddr_q.push_back(base_addr + 32'(model_off * 4));
            exp_awlen_q.push_back(4'(BL - 1));
            model_off = (model_off + BL) % int'(buf_words);
            model_cnt = 0;
        end
        exp_w_q.push_back(e);
    endtask

    task automatic push_word(input logic [31:0] d);
        int n = 0;
        s_data  = d;
        s_valid = 1'b1;
        @(negedge clk);
        while (!s_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            vectors++;
            miscompares++;
            $display("FAIL push_timeout: s_ready=%b, required 1", s_ready);
        end else begin
            model_accept(d);
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic push_words(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) push_word(start + 32'(i));
    endtask

    task automatic set_enable(input logic v);
        wexp_t e;
        @(posedge clk); #1;
        if (v && !enable) begin
            for (int i = 0; i < model_cnt; i++) e = exp_w_q.pop_back();
            model_cnt = 0;
            model_off = 0;
        end
`ifdef F2H_BURST_WRITER_FLUSH_EN
        else if (!v && enable && model_cnt > 0) begin
            e = exp_w_q.pop_back();
            e.last = 1'b1;
            exp_w_q.push_back(e);
            exp_awaddr_q.push_back(base_addr + 32'(model_off * 4));
            exp_awlen_q.push_back(4'(model_cnt - 1));
            model_off = (model_off + model_cnt) % int'(buf_words);
            model_cnt = 0;
        end
`endif
        enable = v;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        @(negedge clk);
        while (!(exp_awaddr_q.size() == 0 && exp_w_q.size() == model_cnt && !busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n >= budget) begin
            miscompares++;
            $display("FAIL %s_timeout: got %0d AW/%0d W pending busy=%b, required drained",
                     name, exp_awaddr_q.size(), exp_w_q.size() - model_cnt, busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        enable = 1'b0;
        s_valid = 1'b0;
        s_data = 32'd0;
        base_addr = 32'h3000_0000;
        buf_words = 24'd64;
        axi.awready = 1'b1;
        axi.wready = 1'b1;
        axi.bvalid = 1'b0;
        axi.bresp = 2'b00;
        axi.bid = 8'h00;
        repeat (5) @(negedge clk);
        vectors++;
        if ({axi.awvalid, axi.wvalid, axi.bready, s_ready, busy, overflow, bresp_err} !== 7'b0 ||
            wr_ptr !== 24'd0) begin
            miscompares++;
            $display("FAIL reset_in: got aw/w/b/sr/busy/ovf/err=%b wr_ptr=%0d, required 0",
                     {axi.awvalid, axi.wvalid, axi.bready, s_ready, busy, overflow, bresp_err}, wr_ptr);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        vectors++;
        if ({axi.awvalid, axi.wvalid, axi.bready, s_ready, busy} !== 5'b0 || wr_ptr !== 24'd0) begin
            miscompares++;
            $display("FAIL reset_out: got aw/w/b/sr/busy=%b wr_ptr=%0d, required 0",
                     {axi.awvalid, axi.wvalid, axi.bready, s_ready, busy}, wr_ptr);
        end
        vectors++;
        if ({axi.awsize, axi.awburst, axi.awlock, axi.awprot, axi.wstrb, axi.awid, axi.wid,
             axi.awcache, axi.awuser} !== {3'b010, 2'b01, 2'b00, 3'b000, 4'hF, 8'h00, 8'h00, 4'b0011, 5'b00000}) begin
            miscompares++;
            $display("FAIL constants: got size=%b burst=%b lock=%b prot=%b strb=%h id=%h/%h cache=%b user=%b, required 010/01/00/000/F/00/00/0011/00000",
                     axi.awsize, axi.awburst, axi.awlock, axi.awprot, axi.wstrb, axi.awid, axi.wid, axi.awcache, axi.awuser);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single_burst;
        int a0, w0;
        set_enable(1'b1);
        a0 = aw_seen;
        w0 = w_seen;
        push_words(32'd0, 16);
        wait_idle("single", 300);
        vectors++;
        if (wr_ptr !== 24'd16) begin
            miscompares++;
            $display("FAIL single_wr_ptr: got %0d, required 16", wr_ptr);
        end
        vectors++;
        if (aw_seen - a0 != 1 || w_seen - w0 != 16) begin
            miscompares++;
            $display("FAIL single_counts: got %0d AW %0d W, required 1 AW 16 W", aw_seen - a0, w_seen - w0);
        end
    endtask

    task automatic test_wrap;
        int a0;
        set_enable(1'b0);
        set_enable(1'b1);
        w_rand = 1'b1;
        a0 = aw_seen;
        push_words(32'h100, 64);
        wait_idle("wrap4", 1000);
        vectors++;
        if (wr_ptr !== 24'd0 || aw_seen - a0 != 4) begin
            miscompares++;
            $display("FAIL wrap_4th: got wr_ptr=%0d bursts=%0d, required 0 and 4", wr_ptr, aw_seen - a0);
        end
        push_words(32'h200, 16);
        wait_idle("wrap5", 500);
        vectors++;
        if (wr_ptr !== 24'd16) begin
            miscompares++;
            $display("FAIL wrap_5th: got wr_ptr=%0d, required 16", wr_ptr);
        end
        w_rand = 1'b0;
    endtask

    task automatic test_bresp_err;
        set_enable(1'b0);
        set_enable(1'b1);
        err_next = 1'b1;
        push_words(32'h300, 16);
        wait_idle("berr1", 300);
        vectors++;
        if (bresp_err !== 1'b1 || wr_ptr !== 24'd16) begin
            miscompares++;
            $display("FAIL bresp_first: got err=%b wr_ptr=%0d, required 1 and 16", bresp_err, wr_ptr);
        end
        push_words(32'h310, 16);
        wait_idle("berr2", 300);
        vectors++;
        if (bresp_err !== 1'b1 || wr_ptr !== 24'd32) begin
            miscompares++;
            $display("FAIL bresp_sticky: got err=%b wr_ptr=%0d, required 1 and 32", bresp_err, wr_ptr);
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] d;
        int acc, bad;
        bit took;
        d = 32'h400;
        acc = 0;
        bad = 0;
        aw_stall = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        s_valid = 1'b1;
        s_data = d;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            took = s_ready;
            if (took) begin
                model_accept(d);
                acc++;
            end
            if (axi.wvalid || (axi.awvalid && (axi.awaddr !== 32'h3000_0080 || axi.awlen !== 4'hF))) bad++;
            @(posedge clk); #1;
            if (took) begin
                d = d + 32'd1;
                s_data = d;
            end
        end
        s_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (acc != 32 || s_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_full: got accepted=%0d s_ready=%b, required 32 and 0", acc, s_ready);
        end
        vectors++;
        if (overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_overflow: got %b, required 1", overflow);
        end
        vectors++;
        if (bad != 0 || axi.awvalid !== 1'b1 || axi.awaddr !== 32'h3000_0080) begin
            miscompares++;
            $display("FAIL bp_stall: got %0d bad cycles awvalid=%b awaddr=%h, required 0/1/30000080",
                     bad, axi.awvalid, axi.awaddr);
        end
        @(posedge clk); #1;
        aw_stall = 1'b0;
        wait_idle("bp", 600);
        vectors++;
        if (wr_ptr !== 24'd0) begin
            miscompares++;
            $display("FAIL bp_wr_ptr: got %0d, required 0", wr_ptr);
        end
    endtask

    task automatic test_flush;
        int a0, w0;
        set_enable(1'b0);
        set_enable(1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        vectors++;
        if (overflow !== 1'b0 || bresp_err !== 1'b0 || wr_ptr !== 24'd0) begin
            miscompares++;
            $display("FAIL rise_clear: got ovf=%b err=%b wr_ptr=%0d, required 0/0/0", overflow, bresp_err, wr_ptr);
        end
        @(posedge clk); #1;
        a0 = aw_seen;
        w0 = w_seen;
        push_words(32'h500, 5);
        set_enable(1'b0);
`ifdef F2H_BURST_WRITER_FLUSH_EN
        wait_idle("flush", 200);
        vectors++;
        if (wr_ptr !== 24'd5 || aw_seen - a0 != 1 || w_seen - w0 != 5) begin
            miscompares++;
            $display("FAIL flush: got wr_ptr=%0d AW=%0d W=%0d, required 5/1/5", wr_ptr, aw_seen - a0, w_seen - w0);
        end
`else
        repeat (30) begin @(posedge clk); #1; end
        vectors++;
        if (wr_ptr !== 24'd0 || aw_seen - a0 != 0 || w_seen - w0 != 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL noflush: got wr_ptr=%0d AW=%0d W=%0d busy=%b, required 0/0/0/0",
                     wr_ptr, aw_seen - a0, w_seen - w0, busy);
        end
`endif
        set_enable(1'b1);
        push_words(32'h600, 16);
        wait_idle("after_flush", 300);
        vectors++;
        if (wr_ptr !== 24'd16 || exp_w_q.size() != 0 || exp_awaddr_q.size() != 0) begin
            miscompares++;
            $display("FAIL after_flush: got wr_ptr=%0d pendingW=%0d pendingAW=%0d, required 16/0/0",
                     wr_ptr, exp_w_q.size(), exp_awaddr_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_wrap();
        test_bresp_err();
        test_backpressure();
        test_flush();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
